// File: rtl/rotator_pkg.sv
// Shared rotator/derotator definitions: FSM states, default widths, direction codes.
package rotator_pkg;

  localparam int unsigned W_DEFAULT  = 8;
  localparam int unsigned SW_DEFAULT = 3;

  // Direction of the original rotation; the derotator undoes it.
  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rot_state_t;

endpackage

// File: rtl/rot1_step.sv
// Combinational single-position rotate of a W-bit word.
module rot1_step #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] d,
  input  logic         rot_right,
  output logic [W-1:0] q
);

  always_comb begin
    if (rot_right) q = {d[0], d[W-1:1]};
    else           q = {d[W-2:0], d[W-1]};
  end

endmodule

// File: rtl/barrel_derotator.sv
// Iterative barrel derotator: one single-bit rotation per clock, opposite to the original direction.
module barrel_derotator
  import rotator_pkg::*;
#(
  parameter int unsigned W  = W_DEFAULT,
  parameter int unsigned SW = SW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  i,
  input  logic [SW-1:0] s,
  input  logic          dir,
  output logic [W-1:0]  o,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  rot_state_t    state, state_nx;
  logic [SW-1:0] count;
  logic          dir_q;
  logic [W-1:0]  o_step;

  // A left-rotated word is restored by rotating right, and vice versa.
  rot1_step #(.W(W)) u_step (
    .d         (o),
    .rot_right (dir_q == DIR_LEFT),
    .q         (o_step)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = (s != '0) ? RUN : DONE;
      RUN:  if (count == SW'(1)) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      o     <= '0;
      count <= '0;
      dir_q <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid) begin
          o     <= i;
          count <= s;
          dir_q <= dir;
        end
        RUN: begin
          o     <= o_step;
          count <= count - SW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);

endmodule

// File: tb/tb_barrel_derotator.sv
// Randomized self-checking bench for barrel_derotator against a rotate-arithmetic model.
module tb_barrel_derotator;

  localparam int unsigned W  = 8;
  localparam int unsigned SW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  i = '0;
  logic [SW-1:0] s = '0;
  logic          dir = 1'b0;
  logic [W-1:0]  o;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  barrel_derotator #(.W(W), .SW(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i         (i),
    .s         (s),
    .dir       (dir),
    .o         (o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Model: plain modular rotate arithmetic on an int.
  function automatic logic [W-1:0] rol(input logic [W-1:0] x, input int unsigned n);
    int unsigned v;
    v = (int'(x) << n) | (int'(x) >> (W - n));
    return v[W-1:0];
  endfunction

  function automatic logic [W-1:0] ror(input logic [W-1:0] x, input int unsigned n);
    return rol(x, (W - n) % W);
  endfunction

  function automatic logic [W-1:0] derot(input logic [W-1:0] x, input int unsigned n, input logic d);
    return d ? ror(x, n) : rol(x, n);
  endfunction

  task automatic run_job(input logic [W-1:0] word, input logic [SW-1:0] amt, input logic d,
                         input logic [W-1:0] exp, input int hold, input bit poke);
    int lat;
    logic [W-1:0] held;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; i = word; s = amt; dir = d;
    @(posedge clk); #1;
    in_valid = 1'b0; i = W'($urandom); s = SW'($urandom); dir = 1'($urandom);
    check("busy_after_accept", busy, 1);
    check("in_ready_after_accept", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < int'(W) + 4) begin
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    out_ready = 1'b0;
    check("latency", lat, amt);
    check("result", o, exp);
    held = o;
    for (int c = 0; c < hold; c++) begin
      if (poke) begin
        in_valid = 1'b1; i = ~held; s = 3'd1; dir = ~d;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("hold_o", o, held);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain_valid", out_valid, 0);
    check("drain_idle", in_ready, 1);
    check("drain_busy", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] w, rotated;
    logic [SW-1:0] amt;
    logic d;

    #12;
    check("reset_o", o, 0);
    check("reset_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;
    check("reset_in_ready", in_ready, 1);

    run_job(8'hA5, 3'd3, 1'b1, 8'hB4, 0, 1'b0);
    run_job(8'h3C, 3'd0, 1'b0, 8'h3C, 0, 1'b0);
    run_job(8'h02, 3'd7, 1'b0, 8'h01, 0, 1'b0);
    run_job(8'h80, 3'd1, 1'b1, derot(8'h80, 1, 1'b1), 0, 1'b0);
    run_job(8'h5A, 3'd2, 1'b0, derot(8'h5A, 2, 1'b0), 5, 1'b1);

    // Asynchronous reset mid-RUN, away from the clock edge.
    @(negedge clk);
    in_valid = 1'b1; i = 8'hC3; s = 3'd6; dir = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0; #1;
    check("midrun_rst_o", o, 0);
    check("midrun_rst_valid", out_valid, 0);
    check("midrun_rst_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;
    check("midrun_rst_in_ready", in_ready, 1);
    repeat (10) @(posedge clk);
    #1;
    check("no_partial_result", out_valid, 0);
    run_job(8'h96, 3'd5, 1'b0, derot(8'h96, 5, 1'b0), 1, 1'b0);

    for (int n = 0; n < 200; n++) begin
      w   = W'($urandom);
      amt = SW'($urandom_range(0, W - 1));
      d   = 1'($urandom);
      rotated = d ? rol(w, amt) : ror(w, amt);
      run_job(rotated, amt, d, w, $urandom_range(0, 3), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
